// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass and a per-register pending (scoreboard) bit.
// Latency: reads, busy and alloc_conflict are combinational; writes, allocs and flush take effect after the clock edge.
// Backpressure: none internally; issue logic stalls on rsX_busy, and alloc_conflict is advisory only.
module regfile_scoreboard #(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int AW        = $clog2(NREGS),
   parameter bit HARD_ZERO = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_addr,
   output logic            alloc_conflict,
   input  logic            flush,
   output logic            any_pending
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;

   logic rs1_zero, rs2_zero, wr_zero, alloc_zero;
   logic rs1_hit, rs2_hit, alloc_hit;

   // Register 0 is hardwired only when HARD_ZERO is set.
   assign rs1_zero   = HARD_ZERO && (rs1_addr == '0);
   assign rs2_zero   = HARD_ZERO && (rs2_addr == '0);
   assign wr_zero    = HARD_ZERO && (wr_addr == '0);
   assign alloc_zero = HARD_ZERO && (alloc_addr == '0);

   // A writeback addressing the same register as a reader or allocator this cycle.
   assign rs1_hit   = wr_en && (wr_addr == rs1_addr);
   assign rs2_hit   = wr_en && (wr_addr == rs2_addr);
   assign alloc_hit = wr_en && (wr_addr == alloc_addr);

   // Read ports: hardwired zero first, then same-cycle bypass, then the array.
   always_comb begin
      rs1_data = regs[rs1_addr];
      rs2_data = regs[rs2_addr];
      if (rs1_hit)  rs1_data = wr_data;
      if (rs2_hit)  rs2_data = wr_data;
      if (rs1_zero) rs1_data = '0;
      if (rs2_zero) rs2_data = '0;
   end

   // A writeback presented this cycle releases the stall immediately.
   assign rs1_busy = !rs1_zero && pending[rs1_addr] && !rs1_hit;
   assign rs2_busy = !rs2_zero && pending[rs2_addr] && !rs2_hit;

   // WAW warning; the allocation is still performed.
   assign alloc_conflict = alloc_en && !alloc_zero && pending[alloc_addr] && !alloc_hit;

   assign any_pending = |pending;

   // Pending update ordering: write clears, a newer alloc re-sets, flush wipes everything.
   always_comb begin
      pending_nxt = pending;
      if (wr_en && !wr_zero)
         pending_nxt[wr_addr] = 1'b0;
      if (alloc_en && !alloc_zero)
         pending_nxt[alloc_addr] = 1'b1;
      if (flush)
         pending_nxt = '0;
   end

   // Scoreboard state register.
   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   // Register contents; only reset blocks a data write, flush does not.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_en && !wr_zero) begin
         regs[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs compared every cycle at the falling edge once the first reset has been applied.
// Backpressure: not applicable; stimulus is driven freely each cycle.
module tb_regfile_scoreboard;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   rs1_addr, rs2_addr;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_busy, rs2_busy;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            alloc_en;
   logic [AW-1:0]   alloc_addr;
   logic            alloc_conflict;
   logic            flush;
   logic            any_pending;

   int tests  = 0;
   int failed = 0;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .HARD_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .alloc_conflict(alloc_conflict),
      .flush(flush), .any_pending(any_pending)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [XLEN-1:0] m_reg  [NREGS];
   bit              m_pend [NREGS];
   bit              m_valid = 1'b0;

   function automatic logic [XLEN-1:0] exp_data(input int a);
      if (a == 0) return '0;
      if (wr_en && int'(wr_addr) == a) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (a == 0) return 1'b0;
      if (wr_en && int'(wr_addr) == a) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic logic exp_conflict();
      int a = int'(alloc_addr);
      if (!alloc_en || a == 0) return 1'b0;
      if (wr_en && int'(wr_addr) == a) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic logic exp_any();
      int n = 0;
      for (int i = 0; i < NREGS; i++) n += int'(m_pend[i]);
      return n != 0;
   endfunction

   // Model state advances on the same edge as the design.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
         end
         m_valid = 1'b1;
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_reg[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
         end
         if (flush) begin
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
         end else if (alloc_en && alloc_addr != 0) begin
            m_pend[alloc_addr] = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("rs1_data", rs1_data, exp_data(int'(rs1_addr)));
         check("rs2_data", rs2_data, exp_data(int'(rs2_addr)));
         check("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(int'(rs1_addr))});
         check("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(int'(rs2_addr))});
         check("alloc_conflict", {31'b0, alloc_conflict}, {31'b0, exp_conflict()});
         check("any_pending", {31'b0, any_pending}, {31'b0, exp_any()});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
      rs1_addr = '0; rs2_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
      tick(); tick();
      idle();

      // Reset state: every register reads zero and nothing is busy.
      for (int i = 0; i < NREGS; i++) begin
         rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
         #1;
         check("rst_rs1_data", rs1_data, 32'h0);
         check("rst_rs2_data", rs2_data, 32'h0);
         check("rst_rs1_busy", {31'b0, rs1_busy}, 32'h0);
         check("rst_any_pending", {31'b0, any_pending}, 32'h0);
         tick();
      end

      // Bypass then persistence.
      wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5;
      #1 check("bypass_x5", rs1_data, 32'hDEADBEEF);
      tick(); idle();
      #1 check("stored_x5", rs1_data, 32'hDEADBEEF);

      // Alloc, writeback releases stall same cycle, pending clears next cycle.
      alloc_en = 1'b1; alloc_addr = 7;
      tick(); idle(); rs2_addr = 7;
      #1 check("busy_x7", {31'b0, rs2_busy}, 32'h1);
      check("any_pending_x7", {31'b0, any_pending}, 32'h1);
      wr_en = 1'b1; wr_addr = 7; wr_data = 32'h12;
      #1 check("release_x7", {31'b0, rs2_busy}, 32'h0);
      check("bypass_x7", rs2_data, 32'h12);
      tick(); idle();
      #1 check("cleared_x7", {31'b0, rs2_busy}, 32'h0);
      check("any_pending_clear", {31'b0, any_pending}, 32'h0);

      // Alloc and write to the same register: newer producer keeps it pending.
      alloc_en = 1'b1; alloc_addr = 3; wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
      tick(); idle(); rs1_addr = 3;
      #1 check("data_x3", rs1_data, 32'h55);
      check("busy_x3", {31'b0, rs1_busy}, 32'h1);
      alloc_en = 1'b1; alloc_addr = 3;
      #1 check("waw_x3", {31'b0, alloc_conflict}, 32'h1);
      tick(); idle();

      // Flush beats a same-cycle alloc.
      alloc_en = 1'b1; alloc_addr = 1; tick();
      alloc_addr = 2; tick();
      alloc_addr = 9; tick();
      alloc_addr = 4; flush = 1'b1; tick(); idle();
      #1 check("flush_any", {31'b0, any_pending}, 32'h0);
      foreach (m_pend[k]) begin
         if (k == 1 || k == 2 || k == 3 || k == 4 || k == 9) begin
            rs1_addr = AW'(k);
            #1 check("flush_busy", {31'b0, rs1_busy}, 32'h0);
         end
      end
      tick();

      // Hardwired zero register.
      wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; alloc_en = 1'b1; alloc_addr = 0; rs1_addr = 0;
      #1 check("x0_bypass", rs1_data, 32'h0);
      check("x0_busy", {31'b0, rs1_busy}, 32'h0);
      tick(); idle();
      #1 check("x0_data", rs1_data, 32'h0);
      check("x0_pending", {31'b0, any_pending}, 32'h0);

      // Reset wins over a same-cycle write.
      wr_en = 1'b1; wr_addr = 6; wr_data = 32'hABCD; tick(); idle();
      rst = 1'b1; wr_en = 1'b1; wr_addr = 6; wr_data = 32'h1234; tick(); idle();
      rs1_addr = 6;
      #1 check("rst_beats_write", rs1_data, 32'h0);
      tick();

      // Randomized traffic; small address window concentrates hazards.
      for (int c = 0; c < 3000; c++) begin
         int win;
         win = ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7;
         rst        = ($urandom_range(0, 199) == 0);
         flush      = ($urandom_range(0, 24) == 0);
         wr_en      = $urandom_range(0, 1);
         alloc_en   = $urandom_range(0, 1);
         wr_addr    = AW'($urandom_range(0, win));
         alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, win));
         rs1_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, win));
         rs2_addr   = AW'($urandom_range(0, win));
         wr_data    = $urandom;
         tick();
      end
      idle();
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
